// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video timing generator:
//   - default horizontal/vertical timing constants (pixels / lines)
//   - derived totals H_TOTAL / V_TOTAL
//   - FSM state encoding (WAIT_LOCK, RUN)
//   - in_window(): half-open range test used by the sync decoders
// ---------------------------------------------------------------------------
package video_pkg;

  // Horizontal timing, in pixel clocks
  localparam int DEF_H_DISPLAY = 320;
  localparam int DEF_H_FRONT   = 20;
  localparam int DEF_H_SYNC    = 32;
  localparam int DEF_H_BACK    = 52;

  // Vertical timing, in lines
  localparam int DEF_V_DISPLAY = 240;
  localparam int DEF_V_FRONT   = 4;
  localparam int DEF_V_SYNC    = 3;
  localparam int DEF_V_BACK    = 15;

  // Derived totals for the default timing (424 x 262)
  localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Counters are 9 bits wide, so no total may exceed this
  localparam int CNT_LIMIT = 512;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  // True when lo <= cnt < hi. Operands are 10 bits so that an upper bound
  // of exactly 512 still compares correctly against a 9-bit counter.
  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for bringing slow, level-type signals into
// the clk domain. Both stages clear on the synchronous reset.
// Ports:
//   clk   in   destination clock
//   rst   in   synchronous active-high reset (clears both stages)
//   i_d   in   asynchronous input, WIDTH bits
//   o_q   out  synchronized output (second stage), WIDTH bits
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Each bit is synchronized independently; no multi-bit coherency is
  // implied, so only feed this with independent level signals.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (rst) begin
          r_meta[gi] <= 1'b0;
          r_sync[gi] <= 1'b0;
        end else begin
          r_meta[gi] <= i_d[gi];
          r_sync[gi] <= r_meta[gi];
        end
      end
    end
  endgenerate

  assign o_q = r_sync;

endmodule

// File: rtl/video_timing.sv
// ---------------------------------------------------------------------------
// video_timing
// Raster timing generator. Waits for the pixel PLL to report lock, then
// scans h_cnt/v_cnt across the full frame and decodes blanking, sync,
// display-enable and frame-start flags directly from the counter registers.
// Losing lock drops straight back to the idle state without finishing the
// frame.
// Ports:
//   clk             in   pixel clock
//   rst             in   synchronous active-high reset
//   locked          in   PLL lock, asynchronous to clk
//   pos_x [8:0]     out  horizontal counter
//   pos_y [8:0]     out  vertical counter
//   hsync, vsync    out  sync pulses, polarity set by SYNC_ACTIVE_HIGH
//   hblank, vblank  out  blanking flags, active-high
//   display_enable  out  high inside the active picture only
//   frame_start     out  one-cycle pulse at pixel (0,0) of each frame
// ---------------------------------------------------------------------------
module video_timing
  import video_pkg::*;
#(
  parameter int H_DISPLAY        = DEF_H_DISPLAY,
  parameter int H_FRONT          = DEF_H_FRONT,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BACK           = DEF_H_BACK,
  parameter int V_DISPLAY        = DEF_V_DISPLAY,
  parameter int V_FRONT          = DEF_V_FRONT,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BACK           = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic [8:0] pos_x,
  output logic [8:0] pos_y,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       display_enable,
  output logic       frame_start
);

  // -------------------------------------------------------------------------
  // Derived timing
  // -------------------------------------------------------------------------
  localparam int LINE_LEN    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int HS_START_I = H_DISPLAY + H_FRONT;
  localparam int HS_END_I   = HS_START_I + H_SYNC;
  localparam int VS_START_I = V_DISPLAY + V_FRONT;
  localparam int VS_END_I   = VS_START_I + V_SYNC;

  // Counter wrap points (totals are at most 512, so last index fits 9 bits)
  localparam logic [8:0] H_LAST = 9'(LINE_LEN - 1);
  localparam logic [8:0] V_LAST = 9'(FRAME_LINES - 1);

  // Decode boundaries at 10 bits so a boundary of 512 is representable
  localparam logic [9:0] H_DISP_W   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP_W   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START_W = 10'(HS_START_I);
  localparam logic [9:0] HS_END_W   = 10'(HS_END_I);
  localparam logic [9:0] VS_START_W = 10'(VS_START_I);
  localparam logic [9:0] VS_END_W   = 10'(VS_END_I);

  // -------------------------------------------------------------------------
  // Elaboration-time sanity checks
  // -------------------------------------------------------------------------
  generate
    if (LINE_LEN > CNT_LIMIT) begin : g_bad_h_total
      $error("video_timing: horizontal total exceeds the 9-bit counter range");
    end
    if (FRAME_LINES > CNT_LIMIT) begin : g_bad_v_total
      $error("video_timing: vertical total exceeds the 9-bit counter range");
    end
    if (H_DISPLAY < 1 || V_DISPLAY < 1) begin : g_bad_display
      $error("video_timing: display area must be at least one pixel/line");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Lock synchronizer
  // -------------------------------------------------------------------------
  logic w_locked_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (locked),
    .o_q (w_locked_s)
  );

  // -------------------------------------------------------------------------
  // State machine and raster counters
  // -------------------------------------------------------------------------
  state_t     r_state;
  logic [8:0] r_h_cnt;
  logic [8:0] r_v_cnt;

  // Counters are held at zero outside RUN, so the first RUN cycle always
  // presents (0,0) and a restart after lock loss begins a fresh frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_LOCK;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_h_cnt <= '0;
          r_v_cnt <= '0;
          if (w_locked_s) begin
            r_state <= RUN;
          end
        end

        RUN: begin
          if (!w_locked_s) begin
            // Abandon the frame immediately
            r_state <= WAIT_LOCK;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
          end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == V_LAST) begin
              r_v_cnt <= '0;
            end else begin
              r_v_cnt <= r_v_cnt + 9'd1;
            end
          end else begin
            r_h_cnt <= r_h_cnt + 9'd1;
          end
        end

        default: begin
          r_state <= WAIT_LOCK;
          r_h_cnt <= '0;
          r_v_cnt <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Flag decode, straight from the counter registers (no extra latency)
  // -------------------------------------------------------------------------
  logic       w_run;
  logic [9:0] w_h_ext;
  logic [9:0] w_v_ext;
  logic       w_h_blank;
  logic       w_v_blank;
  logic       w_hs_act;
  logic       w_vs_act;

  assign w_run   = (r_state == RUN);
  assign w_h_ext = {1'b0, r_h_cnt};
  assign w_v_ext = {1'b0, r_v_cnt};

  assign w_h_blank = (w_h_ext >= H_DISP_W);
  assign w_v_blank = (w_v_ext >= V_DISP_W);

  // vsync depends only on the line number, so it spans whole lines
  assign w_hs_act = w_run && in_window(w_h_ext, HS_START_W, HS_END_W);
  assign w_vs_act = w_run && in_window(w_v_ext, VS_START_W, VS_END_W);

  assign pos_x          = r_h_cnt;
  assign pos_y          = r_v_cnt;
  assign hblank         = !w_run || w_h_blank;
  assign vblank         = !w_run || w_v_blank;
  assign display_enable = w_run && !w_h_blank && !w_v_blank;
  assign frame_start    = w_run && (r_h_cnt == 9'd0) && (r_v_cnt == 9'd0);
  assign hsync          = SYNC_ACTIVE_HIGH ? w_hs_act : !w_hs_act;
  assign vsync          = SYNC_ACTIVE_HIGH ? w_vs_act : !w_vs_act;

endmodule

// File: tb/tb_video_timing.sv
// ---------------------------------------------------------------------------
// tb_video_timing
// Three instances share clk/rst/locked:
//   u_small : reduced 16x11 timing, active-low syncs (full-frame checks)
//   u_def   : default 424x262 timing, active-low syncs (boundaries, lock loss)
//   u_hi    : reduced timing with active-high syncs (polarity comparison)
// Observations are packed as {pos_x, pos_y, hs, vs, hb, vb, de, fs}.
// ---------------------------------------------------------------------------
module tb_video_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b1;

  always #5 clk = ~clk;

  // Small timing: H 8/2/3/3 = 16, V 6/1/2/2 = 11, frame = 176 clocks
  localparam int S_FRAME = 176;

  logic [8:0] s_x, s_y, d_x, d_y, h_x, h_y;
  logic s_hs, s_vs, s_hb, s_vb, s_de, s_fs;
  logic d_hs, d_vs, d_hb, d_vb, d_de, d_fs;
  logic h_hs, h_vs, h_hb, h_vb, h_de, h_fs;

  video_timing #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE_HIGH(1'b0)
  ) u_small (
    .clk(clk), .rst(rst), .locked(locked),
    .pos_x(s_x), .pos_y(s_y), .hsync(s_hs), .vsync(s_vs),
    .hblank(s_hb), .vblank(s_vb), .display_enable(s_de), .frame_start(s_fs)
  );

  video_timing u_def (
    .clk(clk), .rst(rst), .locked(locked),
    .pos_x(d_x), .pos_y(d_y), .hsync(d_hs), .vsync(d_vs),
    .hblank(d_hb), .vblank(d_vb), .display_enable(d_de), .frame_start(d_fs)
  );

  video_timing #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE_HIGH(1'b1)
  ) u_hi (
    .clk(clk), .rst(rst), .locked(locked),
    .pos_x(h_x), .pos_y(h_y), .hsync(h_hs), .vsync(h_vs),
    .hblank(h_hb), .vblank(h_vb), .display_enable(h_de), .frame_start(h_fs)
  );

  logic [23:0] obs_s, obs_d, obs_h;
  assign obs_s = {s_x, s_y, s_hs, s_vs, s_hb, s_vb, s_de, s_fs};
  assign obs_d = {d_x, d_y, d_hs, d_vs, d_hb, d_vb, d_de, d_fs};
  assign obs_h = {h_x, h_y, h_hs, h_vs, h_hb, h_vb, h_de, h_fs};

  // Idle (WAIT_LOCK) observations
  localparam logic [23:0] IDLE_LO = {9'd0, 9'd0, 6'b111100};
  localparam logic [23:0] IDLE_HI = {9'd0, 9'd0, 6'b001100};

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;    // clocks since first RUN cycle
  bit mon_en  = 1'b0;
  bit pol_en  = 1'b0;

  // Frame statistics for u_small, gathered over k in [0, S_FRAME)
  int de_cnt = 0, fs_cnt = 0;
  int hs_cyc = 0, hs_pulses = 0, hs_run = 0, hs_badlen = 0;
  int vs_cyc = 0, vs_pulses = 0, vs_run = 0, vs_badlen = 0;
  int pol_diff = 0;

  typedef struct {
    int         k;
    int         inst;   // 0 = small, 1 = default, 2 = small active-high
    logic [8:0] x;
    logic [8:0] y;
    logic [5:0] fl;     // {hs, vs, hb, vb, de, fs}
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int kk, input int inst, input int x, input int y,
                     input logic [5:0] fl, input string name);
    vec_t v;
    v.k = kk; v.inst = inst; v.x = 9'(x); v.y = 9'(y); v.fl = fl; v.name = name;
    tbl.push_back(v);
  endtask

  function automatic logic [23:0] obs_of(input int inst);
    case (inst)
      0:       return obs_s;
      1:       return obs_d;
      default: return obs_h;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_obs(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pos=(%0d,%0d) hs/vs/hb/vb/de/fs=%b, want pos=(%0d,%0d) %b",
               name, act[23:15], act[14:6], act[5:0], exp[23:15], exp[14:6], exp[5:0]);
    end else begin
      $display("[TB] %s ok pos=(%0d,%0d) flags=%b", name, act[23:15], act[14:6], act[5:0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("[TB] %s ok = %0d", name, act);
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (pol_en) begin
      // Only the two sync bits may differ between the polarity variants
      if ((obs_s ^ obs_h) !== 24'h000030) pol_diff++;
    end
    if (mon_en && k < S_FRAME) begin
      if (s_de) de_cnt++;
      if (s_fs) fs_cnt++;
      if (!s_hs) begin
        hs_cyc++; hs_run++;
      end else if (hs_run != 0) begin
        hs_pulses++;
        if (hs_run != 3) hs_badlen++;
        hs_run = 0;
      end
      if (!s_vs) begin
        vs_cyc++; vs_run++;
      end else if (vs_run != 0) begin
        vs_pulses++;
        if (vs_run != 32) vs_badlen++;
        vs_run = 0;
      end
    end
  end

  initial begin
    // ---- vector table, sorted by k ----
    add(0,     0, 0,   0,  6'b110011, "s_first_pixel");
    add(0,     1, 0,   0,  6'b110011, "d_first_pixel");
    add(0,     2, 0,   0,  6'b000011, "hi_first_pixel");
    add(7,     0, 7,   0,  6'b110010, "s_last_active_x");
    add(8,     0, 8,   0,  6'b111000, "s_hblank_rise");
    add(10,    0, 10,  0,  6'b011000, "s_hsync_start");
    add(10,    2, 10,  0,  6'b101000, "hi_hsync_start");
    add(12,    0, 12,  0,  6'b011000, "s_hsync_last");
    add(13,    0, 13,  0,  6'b111000, "s_hsync_end");
    add(15,    0, 15,  0,  6'b111000, "s_line_end");
    add(16,    0, 0,   1,  6'b110010, "s_line1_start");
    add(95,    0, 15,  5,  6'b111000, "s_last_active_line_end");
    add(96,    0, 0,   6,  6'b110100, "s_vblank_rise");
    add(112,   0, 0,   7,  6'b100100, "s_vsync_start");
    add(123,   0, 11,  7,  6'b001100, "s_both_syncs");
    add(123,   2, 11,  7,  6'b111100, "hi_both_syncs");
    add(143,   0, 15,  8,  6'b101100, "s_vsync_last");
    add(144,   0, 0,   9,  6'b110100, "s_vsync_end");
    add(175,   0, 15,  10, 6'b111100, "s_frame_last");
    add(176,   0, 0,   0,  6'b110011, "s_frame_wrap");
    add(186,   0, 10,  0,  6'b011000, "s_frame2_hsync");
    add(319,   1, 319, 0,  6'b110010, "d_last_active_x");
    add(320,   1, 320, 0,  6'b111000, "d_hblank_rise");
    add(339,   1, 339, 0,  6'b111000, "d_before_hsync");
    add(340,   1, 340, 0,  6'b011000, "d_hsync_start");
    add(371,   1, 371, 0,  6'b011000, "d_hsync_last");
    add(372,   1, 372, 0,  6'b111000, "d_hsync_end");
    add(423,   1, 423, 0,  6'b111000, "d_line_end");
    add(424,   1, 0,   1,  6'b110010, "d_line1_start");
    add(4663,  1, 423, 10, 6'b111000, "d_line10_end");
    add(4664,  1, 0,   11, 6'b110010, "d_line11_start");
    add(21300, 1, 100, 50, 6'b110010, "d_pos_100_50");

    // ---- reset with locked high ----
    for (int i = 0; i < 4; i++) begin
      tick();
      pol_en = 1'b1;
      chk_obs($sformatf("rst_s_%0d", i), obs_s, IDLE_LO);
      chk_obs($sformatf("rst_d_%0d", i), obs_d, IDLE_LO);
      chk_obs($sformatf("rst_hi_%0d", i), obs_h, IDLE_HI);
    end
    rst = 1'b0;
    tick();
    chk_obs("post_rst_edge1", obs_s, IDLE_LO);
    tick();
    chk_obs("post_rst_edge2", obs_d, IDLE_LO);
    tick();            // third edge: RUN, k = 0
    k = 0;
    mon_en = 1'b1;

    // ---- table walk ----
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        tick();
        k++;
      end
      chk_obs(tbl[i].name, obs_of(tbl[i].inst), {tbl[i].x, tbl[i].y, tbl[i].fl});
    end

    // ---- full-frame statistics on the reduced timing ----
    chk_int("frame_de_cycles",   de_cnt,    48);
    chk_int("frame_fs_count",    fs_cnt,    1);
    chk_int("frame_hs_cycles",   hs_cyc,    33);
    chk_int("frame_hs_pulses",   hs_pulses, 11);
    chk_int("frame_hs_badlen",   hs_badlen, 0);
    chk_int("frame_vs_cycles",   vs_cyc,    32);
    chk_int("frame_vs_pulses",   vs_pulses, 1);
    chk_int("frame_vs_badlen",   vs_badlen, 0);

    // ---- lock loss at (100,50) on the default timing ----
    locked = 1'b0;
    tick();
    tick();
    chk_obs("lock_drop_edge2", obs_d, {9'd102, 9'd50, 6'b110010});
    tick();
    chk_obs("lock_drop_edge3_d", obs_d, IDLE_LO);
    chk_obs("lock_drop_edge3_s", obs_s, IDLE_LO);
    repeat (5) tick();
    chk_obs("lock_idle_hold", obs_d, IDLE_LO);
    locked = 1'b1;
    tick();
    tick();
    chk_obs("relock_edge2", obs_d, IDLE_LO);
    tick();
    chk_obs("relock_edge3_d", obs_d, {9'd0, 9'd0, 6'b110011});
    chk_obs("relock_edge3_s", obs_s, {9'd0, 9'd0, 6'b110011});
    tick();
    chk_obs("relock_next", obs_d, {9'd1, 9'd0, 6'b110010});

    // ---- polarity variants must differ only in the sync bits ----
    chk_int("polarity_diff_cycles", pol_diff, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 Parameter H_DISPLAY, default 320, active pixels per line.
REQ-002 Parameter H_FRONT, default 20, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 32, hsync width in pixels.
REQ-004 Parameter H_BACK, default 52, horizontal back porch in pixels; H_TOTAL = 424.
REQ-005 Parameter V_DISPLAY / V_FRONT / V_SYNC / V_BACK, defaults 240 / 4 / 3 / 15, in lines; V_TOTAL = 262.
REQ-006 Parameter SYNC_ACTIVE_HIGH, default 0; 0 means hsync/vsync are active-low.
REQ-007 clk  input  1  pixel clock, 6.6 MHz PLL output; single clock domain.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 locked  input  1  PLL lock indication, asynchronous to clk.
REQ-010 pos_x  output  9  horizontal counter (h_cnt).
REQ-011 pos_y  output  9  vertical counter (v_cnt).
REQ-012 hsync, vsync  output  1 each  sync pulses, polarity per SYNC_ACTIVE_HIGH.
REQ-013 hblank, vblank  output  1 each  blanking flags, active-high.
REQ-014 display_enable  output  1  high only inside the active area.
REQ-015 frame_start  output  1  one-cycle pulse at the first pixel of each frame.

Function
REQ-016 locked SHALL pass through a 2-flop synchronizer; locked_s is the second-stage output.
REQ-017 FSM states: WAIT_LOCK and RUN.
REQ-018 WAIT_LOCK -> RUN on the edge where locked_s = 1; RUN -> WAIT_LOCK on the edge where locked_s = 0.
REQ-019 In WAIT_LOCK: h_cnt = v_cnt = 0; hblank = vblank = 1; display_enable = 0; frame_start = 0; syncs inactive.
REQ-020 In RUN, h_cnt SHALL increment each clk and wrap from H_TOTAL-1 to 0.
REQ-021 v_cnt SHALL increment only on that wrap, and wrap from V_TOTAL-1 to 0.
REQ-022 The first RUN cycle SHALL present h_cnt = 0, v_cnt = 0.
REQ-023 hblank = (h_cnt >= H_DISPLAY); vblank = (v_cnt >= V_DISPLAY); display_enable = !hblank && !vblank (all RUN only).
REQ-024 hsync SHALL be active for h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC), i.e. [340,372) by default.
REQ-025 vsync SHALL be active for v_cnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC), i.e. [244,247) by default, for entire lines.
REQ-026 frame_start = 1 iff RUN and h_cnt = 0 and v_cnt = 0.
REQ-027 All flags SHALL be decoded from the h_cnt/v_cnt registers, aligned in the same cycle as pos_x/pos_y, with zero additional latency.
REQ-028 Counters are 9-bit unsigned; parameter totals SHALL NOT exceed 512 (elaboration-time check).
REQ-029 Loss of lock mid-frame: the next edge after locked_s falls SHALL enter WAIT_LOCK with all outputs at their REQ-019 values; there is no frame completion.

Reset
REQ-030 rst SHALL force WAIT_LOCK, clear both synchronizer flops and both counters, and drive outputs to their REQ-019 values.
REQ-031 rst has priority over locked on the same edge.
REQ-032 After rst deasserts with locked held high, RUN SHALL be entered on the 3rd clk edge.

Structure
REQ-033 Shared package video_pkg holds the default timing constants, the derived H_TOTAL/V_TOTAL, and the FSM state enum.
REQ-034 Sub-module sync_2ff (generic 2-flop synchronizer, reset by rst) is instantiated for locked; everything else is inline.

Verification
REQ-035 rst high 4 cycles, locked=1 throughout -> outputs at REQ-019 values during reset; frame_start=1 with pos=(0,0) on 3rd edge after rst falls.
REQ-036 Run one full frame -> frame_start period exactly 111088 clks; 262 hsync pulses of 32 clks each; one vsync pulse of 3×424 = 1272 clks.
REQ-037 Run one full frame -> display_enable high for exactly 320×240 = 76800 clks per frame; hblank rises at pos_x=320; vblank rises at pos_y=240.
REQ-038 Drop locked at pos=(100,50) -> within 3 clks WAIT_LOCK, pos=(0,0), hblank=vblank=1; re-raise locked -> fresh frame from (0,0) with frame_start.
REQ-039 SYNC_ACTIVE_HIGH=1 vs 0 -> hsync/vsync inverted, all other outputs identical cycle-for-cycle.
REQ-040 Wrap boundary: pos=(423,261) -> next clk pos=(0,0) with frame_start=1; pos=(423,10) -> next clk pos=(0,11).
